// File: rtl/step_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen_if
// Description : Command/status bundle between the motion controller and one
//               step_pulse_gen channel. The master modport belongs to the
//               controller; the slave modport belongs to the pulse generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface step_pulse_gen_if #(
  parameter int SIZE  = 16,
  parameter int CNT_W = 16
);
  logic             d_v;
  logic [SIZE-1:0]  n;
  logic [1:0]       mode;
  logic             start;
  logic             abort;
  logic             drv_en_SM;
  logic [CNT_W-1:0] pulse_num;
  logic             drv_step;
  logic             drv_invert_step;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulses_left;

  modport master (
    output d_v, n, mode, start, abort, drv_en_SM, pulse_num,
    input  drv_step, drv_invert_step, busy, done, pulses_left
  );

  modport slave (
    input  d_v, n, mode, start, abort, drv_en_SM, pulse_num,
    output drv_step, drv_invert_step, busy, done, pulses_left
  );
endinterface
`default_nettype wire

// File: rtl/step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_pulse_gen
// Description : 25 %-duty STEP pulse generator for one stepper driver channel
//               with stop / continuous / count-N / auto run modes, a runt-free
//               abort path and busy/done status.
//               Optional feature macro: STEP_RAMP_EN (auto-mode accel ramp).
// Revision    : 1.0 - initial release
// ============================================================================
module step_pulse_gen #(
  parameter int SIZE         = 16,
  parameter int CNT_W        = 16,
  parameter int MIN_PERIOD   = 8,
  parameter int START_PERIOD = 2000,
  parameter int RAMP_DEC     = 16
) (
  input wire logic        clk,
  input wire logic        rst_n,
  step_pulse_gen_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RUN  = 2'd1;
  localparam logic [1:0] c_ST_STOP = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  localparam logic [1:0] c_MODE_STOP = 2'b00;
  localparam logic [1:0] c_MODE_CNT  = 2'b10;

  localparam logic [SIZE-1:0]  c_MIN_P = SIZE'(MIN_PERIOD);
  localparam logic [SIZE-1:0]  c_ONE_P = SIZE'(1);
  localparam logic [CNT_W-1:0] c_ONE_C = CNT_W'(1);

  // Period must leave room for a non-empty high phase; ramp must move.
  if (MIN_PERIOD < 4 || START_PERIOD < 4 || RAMP_DEC < 1) begin : g_param_check
    $error("step_pulse_gen: MIN_PERIOD/START_PERIOD must be >= 4, RAMP_DEC >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [SIZE-1:0]  number_q;
  logic [SIZE-1:0]  period_q, period_d;
  logic [SIZE-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] left_q, left_d;
  logic             step_q, step_d;
  logic             inv_q;

  logic [SIZE-1:0]  w_target;
  logic [SIZE-1:0]  w_next_period;
  logic [SIZE-1:0]  w_first_period;
  logic [SIZE-1:0]  w_phase_inc;
  logic             w_start_ok;
  logic             w_stop_req;
  logic             w_last_phase;
  logic             w_hold_high;
  logic             w_zero_cnt;

  assign w_target     = (number_q < c_MIN_P) ? c_MIN_P : number_q;
  assign w_phase_inc  = phase_q + c_ONE_P;
  assign w_last_phase = (phase_q == period_q - c_ONE_P);
  assign w_start_ok   = bus.start && bus.drv_en_SM && !bus.abort && (bus.mode != c_MODE_STOP);
  assign w_stop_req   = bus.abort || !bus.drv_en_SM;
  assign w_zero_cnt   = (bus.mode == c_MODE_CNT) && (bus.pulse_num == '0);
  // A pulse already high keeps going until its full high phase is served.
  assign w_hold_high  = step_q && (w_phase_inc < (period_q >> 2));

`ifdef STEP_RAMP_EN
  localparam logic [1:0]      c_MODE_AUTO  = 2'b11;
  localparam logic [SIZE:0]   c_RAMP_DEC_X = (SIZE+1)'(RAMP_DEC);
  localparam logic [SIZE-1:0] c_RAMP_DEC_S = SIZE'(RAMP_DEC);
  localparam logic [SIZE-1:0] c_START_P    = SIZE'(START_PERIOD);

  logic [SIZE:0] w_ramp_floor;

  // Extra bit keeps T + RAMP_DEC from wrapping near the top of the range.
  assign w_ramp_floor   = {1'b0, w_target} + c_RAMP_DEC_X;
  assign w_first_period = (bus.mode == c_MODE_AUTO) ? c_START_P : w_target;

  // Auto mode steps the period down towards T; other modes track T.
  always_comb begin
    w_next_period = w_target;
    if (mode_q == c_MODE_AUTO && {1'b0, period_q} >= w_ramp_floor) begin
      w_next_period = period_q - c_RAMP_DEC_S;
    end
  end
`else
  assign w_first_period = w_target;
  assign w_next_period  = w_target;
`endif

  // Commanded period word, loaded whenever the command path presents one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number_q <= c_MIN_P;
    end else if (bus.d_v) begin
      number_q <= bus.n;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; stop requests outrank count completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (w_start_ok) state_d = w_zero_cnt ? c_ST_DONE : c_ST_RUN;
      c_ST_RUN: begin
        if (w_stop_req) begin
          state_d = c_ST_STOP;
        end else if (w_last_phase && mode_q == c_MODE_CNT && left_q == c_ONE_C) begin
          state_d = c_ST_DONE;
        end
      end
      c_ST_STOP: if (!w_hold_high) state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // Datapath next values: phase counter, period reload, pulse count, STEP.
  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    phase_d  = phase_q;
    left_d   = left_q;
    step_d   = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (w_start_ok) begin
          mode_d   = bus.mode;
          left_d   = bus.pulse_num;
          period_d = w_first_period;
          phase_d  = '0;
          step_d   = !w_zero_cnt;
        end
      end
      c_ST_RUN: begin
        if (w_stop_req) begin
          phase_d = w_phase_inc;
          step_d  = w_hold_high;
        end else if (w_last_phase) begin
          phase_d = '0;
          if (mode_q == c_MODE_CNT) begin
            left_d = left_q - c_ONE_C;
            step_d = (left_q != c_ONE_C);
          end else begin
            period_d = w_next_period;
            step_d   = 1'b1;
          end
        end else begin
          phase_d = w_phase_inc;
          step_d  = (w_phase_inc < (period_q >> 2));
        end
      end
      c_ST_STOP: begin
        phase_d = w_phase_inc;
        step_d  = w_hold_high;
      end
      default: step_d = 1'b0;
    endcase
  end

  // Datapath registers; the inverted STEP copy lags by one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= c_MODE_STOP;
      period_q <= c_MIN_P;
      phase_q  <= '0;
      left_q   <= '0;
      step_q   <= 1'b0;
      inv_q    <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      phase_q  <= phase_d;
      left_q   <= left_d;
      step_q   <= step_d;
      inv_q    <= !step_q;
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    bus.busy = (state_q == c_ST_RUN) || (state_q == c_ST_STOP);
    bus.done = (state_q == c_ST_DONE);
  end

  assign bus.drv_step        = step_q;
  assign bus.drv_invert_step = inv_q;
  assign bus.pulses_left     = left_q;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_pulse_gen
// Description : Scoreboard bench for step_pulse_gen. Stimulus pushes the
//               expected pulse/done/stop events; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_pulse_gen;

  localparam int SIZE         = 16;
  localparam int CNT_W        = 16;
  localparam int MIN_PERIOD   = 8;
  localparam int START_PERIOD = 400;
  localparam int RAMP_DEC     = 100;

  localparam int EV_PULSE = 0;  // a = high length, b = rise-to-rise interval
  localparam int EV_DONE  = 1;  // a = cycles after start, b = busy, c = pulses_left
  localparam int EV_STOP  = 2;  // a = cycles after stop request, b = drv_step

  typedef struct {
    int kind;
    int a;
    int b;
    int c;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc       = 0;
  int   n_checks  = 0;
  int   n_fail    = 0;
  int   start_ref = 0;
  int   stop_ref  = 0;
  int   last_rise = 0;
  ev_t  exp_q[$];

  step_pulse_gen_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  step_pulse_gen #(
    .SIZE(SIZE), .CNT_W(CNT_W), .MIN_PERIOD(MIN_PERIOD),
    .START_PERIOD(START_PERIOD), .RAMP_DEC(RAMP_DEC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_PULSE: return "pulse";
      EV_DONE:  return "done";
      default:  return "stop";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int k, input int a, input int b, input int c);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.c = c;
    exp_q.push_back(e);
  endtask

  task automatic got(input int k, input int a, input int b, input int c);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected %s event: got a=%0d b=%0d c=%0d at cycle %0d, required no event",
               kname(k), a, b, c, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a != a || e.b != b || e.c != c) begin
        n_fail++;
        $display("FAIL %s event at cycle %0d: got %s a=%0d b=%0d c=%0d, required %s a=%0d b=%0d c=%0d",
                 kname(e.kind), cyc, kname(k), a, b, c, kname(e.kind), e.a, e.b, e.c);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and checks the inverse.
  initial begin
    logic prev_step;
    logic prev_busy;
    logic skip_inv;
    int   rise_cyc;
    int   last_int;
    prev_step = 1'b0; prev_busy = 1'b0; skip_inv = 1'b1;
    rise_cyc  = 0;    last_int  = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_step = 1'b0; prev_busy = 1'b0; skip_inv = 1'b1;
      end else begin
        if (!skip_inv) chk("invert_step_lag", int'(bus.drv_invert_step), int'(!prev_step));
        skip_inv = 1'b0;
        if (bus.drv_step && !prev_step) begin
          last_int  = cyc - last_rise;
          last_rise = cyc;
          rise_cyc  = cyc;
        end
        if (!bus.drv_step && prev_step) got(EV_PULSE, cyc - rise_cyc, last_int, 0);
        if (bus.done) got(EV_DONE, cyc - start_ref, int'(bus.busy), int'(bus.pulses_left));
        if (!bus.busy && prev_busy && !bus.done) got(EV_STOP, cyc - stop_ref, int'(bus.drv_step), 0);
        prev_step = bus.drv_step;
        prev_busy = bus.busy;
      end
    end
  end

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic load_n(input int v);
    bus.n   = SIZE'(v);
    bus.d_v = 1'b1;
    @(negedge clk);
    bus.d_v = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] m, input int pn);
    bus.mode      = m;
    bus.pulse_num = CNT_W'(pn);
    bus.start     = 1'b1;
    start_ref     = cyc;
    last_rise     = cyc;
    @(negedge clk);
    bus.start     = 1'b0;
  endtask

  task automatic wait_off(input int k);
    while (cyc < start_ref + k) @(negedge clk);
  endtask

  // sel=0 pulses abort, sel=1 drops the driver enable, for 'hold' cycles.
  task automatic stop_req(input int sel, input int hold);
    stop_ref = cyc;
    if (sel == 0) bus.abort = 1'b1;
    else          bus.drv_en_SM = 1'b0;
    tick(hold);
    bus.abort     = 1'b0;
    bus.drv_en_SM = 1'b1;
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin
      @(negedge clk);
      i++;
    end
    while (exp_q.size() != 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing %s event: got timeout at cycle %0d, required a=%0d b=%0d c=%0d",
               kname(e.kind), cyc, e.a, e.b, e.c);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.d_v       = 1'b0;
    bus.n         = '0;
    bus.mode      = 2'b00;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.drv_en_SM = 1'b1;
    bus.pulse_num = '0;
    tick(2);
    chk("reset_step", int'(bus.drv_step), 0);
    chk("reset_inv", int'(bus.drv_invert_step), 1);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_left", int'(bus.pulses_left), 0);
    rst_n = 1'b1;
    tick(3);

    // Continuous at 100, retarget to 60 during period 2, abort in low phase.
    load_n(100);
    push(EV_PULSE, 25, 1, 0);   push(EV_PULSE, 25, 100, 0); push(EV_PULSE, 15, 100, 0);
    push(EV_PULSE, 15, 60, 0);  push(EV_PULSE, 15, 60, 0);  push(EV_STOP, 2, 0, 0);
    begin_run(2'b01, 5);
    wait_off(150);
    load_n(60);
    wait_off(350);
    stop_req(0, 3);
    drain(100);
    tick(20);

    // Count-N: three pulses of 40.
    load_n(40);
    push(EV_PULSE, 10, 1, 0); push(EV_PULSE, 10, 40, 0); push(EV_PULSE, 10, 40, 0);
    push(EV_DONE, 121, 0, 0);
    begin_run(2'b10, 3);
    drain(300);
    chk("cnt_busy_after", int'(bus.busy), 0);
    chk("cnt_left_after", int'(bus.pulses_left), 0);
    tick(10);

    // Zero count: done straight away, no pulse.
    push(EV_DONE, 1, 0, 0);
    begin_run(2'b10, 0);
    drain(20);
    tick(10);

    // Ignored starts: mode 00, and start together with abort.
    begin_run(2'b00, 4);
    tick(3);
    chk("mode00_busy", int'(bus.busy), 0);
    bus.abort = 1'b1;
    begin_run(2'b01, 4);
    bus.abort = 1'b0;
    tick(3);
    chk("start_abort_busy", int'(bus.busy), 0);
    tick(5);

    // Abort at clock 10 of the high phase: pulse still 25 wide.
    load_n(100);
    push(EV_PULSE, 25, 1, 0); push(EV_STOP, 15, 0, 0);
    begin_run(2'b01, 0);
    wait_off(11);
    stop_req(0, 20);
    drain(50);
    tick(20);

    // Same with the driver enable dropped.
    push(EV_PULSE, 25, 1, 0); push(EV_STOP, 15, 0, 0);
    begin_run(2'b01, 0);
    wait_off(11);
    stop_req(1, 20);
    drain(50);
    tick(20);

    // Auto mode towards T=120.
    load_n(120);
`ifdef STEP_RAMP_EN
    push(EV_PULSE, 100, 1, 0);  push(EV_PULSE, 75, 400, 0); push(EV_PULSE, 50, 300, 0);
    push(EV_PULSE, 30, 200, 0); push(EV_PULSE, 30, 120, 0); push(EV_PULSE, 30, 120, 0);
    push(EV_STOP, 2, 0, 0);
    begin_run(2'b11, 0);
    wait_off(1200);
`else
    push(EV_PULSE, 30, 1, 0);
    for (int i = 0; i < 5; i++) push(EV_PULSE, 30, 120, 0);
    push(EV_STOP, 2, 0, 0);
    begin_run(2'b11, 0);
    wait_off(650);
`endif
    stop_req(0, 3);
    drain(100);
    tick(20);

    // Period below the minimum is clamped to MIN_PERIOD.
    load_n(3);
    push(EV_PULSE, 2, 1, 0); push(EV_PULSE, 2, 8, 0); push(EV_DONE, 17, 0, 0);
    begin_run(2'b10, 2);
    drain(100);
    tick(10);

    // Asynchronous reset in the middle of a high phase.
    load_n(100);
    begin_run(2'b01, 7);
    wait_off(5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_step", int'(bus.drv_step), 0);
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_inv", int'(bus.drv_invert_step), 1);
    chk("async_rst_left", int'(bus.pulses_left), 0);
    tick(2);
    #2 rst_n = 1'b1;
    tick(5);
    chk("post_rst_step", int'(bus.drv_step), 0);
    chk("post_rst_inv", int'(bus.drv_invert_step), 1);
    chk("post_rst_busy", int'(bus.busy), 0);
    chk("post_rst_done", int'(bus.done), 0);
    chk("post_rst_left", int'(bus.pulses_left), 0);

    // The period register came back at MIN_PERIOD.
    push(EV_PULSE, 2, 1, 0); push(EV_DONE, 9, 0, 0);
    begin_run(2'b10, 1);
    drain(50);
    tick(10);
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
